// File: rtl/game_state_ctrl_if.sv
// game_state_ctrl_if: gameplay event inputs and score/state outputs of the game-state controller
interface game_state_ctrl_if;
    logic       start_btn;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       frame_tick;
    logic [4:0] points;
    logic [1:0] lives;
    logic       playing;
    logic       game_over;
    logic       game_won;
    modport master (
        output start_btn, hit_pulse, miss_pulse, frame_tick,
        input  points, lives, playing, game_over, game_won
    );
    modport slave (
        input  start_btn, hit_pulse, miss_pulse, frame_tick,
        output points, lives, playing, game_over, game_won
    );
endinterface

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: IDLE/PLAYING/OVER sequencer tracking score and lives, feeding the game-over overlay
module game_state_ctrl #(
    parameter int unsigned MAX_POINTS       = 31,
    parameter int unsigned START_LIVES      = 3,
    parameter int unsigned OVER_HOLD_FRAMES = 180
) (
    input  logic              clk,
    input  logic              rst,
    game_state_ctrl_if.slave  io_gs
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAYING = 2'd1, OVER = 2'd2} state_t;

    state_t      r_state, w_state_nx;
    logic        r_start_d;
    logic [4:0]  r_points, w_points_nx;
    logic [1:0]  r_lives, w_lives_nx;
    logic        r_won, w_won_nx;
    logic [9:0]  r_hold, w_hold_nx;
    logic        r_playing, r_game_over;
    logic        w_start_rise, w_win, w_lose;
    logic [4:0]  w_points_inc;
    logic [9:0]  w_hold_inc;

    assign w_start_rise = io_gs.start_btn & ~r_start_d;
    assign w_points_inc = r_points + 5'd1;
    assign w_hold_inc   = r_hold + 10'd1;
    assign w_win        = io_gs.hit_pulse && (w_points_inc == 5'(MAX_POINTS));
    assign w_lose       = io_gs.miss_pulse && (r_lives <= 2'd1);

    always_comb begin
        w_state_nx  = r_state;
        w_points_nx = r_points;
        w_lives_nx  = r_lives;
        w_won_nx    = r_won;
        w_hold_nx   = r_hold;
        case (r_state)
            IDLE: if (w_start_rise) begin
                w_state_nx  = PLAYING;
                w_points_nx = 5'd0;
                w_lives_nx  = 2'(START_LIVES);
                w_won_nx    = 1'b0;
            end
            PLAYING: begin
                w_points_nx = io_gs.hit_pulse ? w_points_inc : r_points;
                w_lives_nx  = (io_gs.miss_pulse && r_lives != 2'd0) ? r_lives - 2'd1 : r_lives;
                // a simultaneous win and loss counts as a win
                if (w_win || w_lose) begin
                    w_state_nx = OVER;
                    w_hold_nx  = 10'd0;
                    w_won_nx   = w_win;
                end
            end
            OVER: if (io_gs.frame_tick) begin
                w_hold_nx  = w_hold_inc;
                w_state_nx = (w_hold_inc == 10'(OVER_HOLD_FRAMES)) ? IDLE : OVER;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_start_d   <= 1'b0;
            r_points    <= 5'd0;
            r_lives     <= 2'd0;
            r_won       <= 1'b0;
            r_hold      <= 10'd0;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_start_d   <= io_gs.start_btn;
            r_points    <= w_points_nx;
            r_lives     <= w_lives_nx;
            r_won       <= w_won_nx;
            r_hold      <= w_hold_nx;
            r_playing   <= (w_state_nx == PLAYING);
            r_game_over <= (w_state_nx == OVER);
        end
    end

    assign io_gs.points    = r_points;
    assign io_gs.lives     = r_lives;
    assign io_gs.playing   = r_playing;
    assign io_gs.game_over = r_game_over;
    assign io_gs.game_won  = r_won;
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed-sequence bench for game_state_ctrl with a 4-frame OVER hold
module tb_game_state_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    game_state_ctrl_if gs ();

    game_state_ctrl #(
        .MAX_POINTS(31),
        .START_LIVES(3),
        .OVER_HOLD_FRAMES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_gs(gs.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic h, input logic m, input logic f, input logic s);
        gs.hit_pulse = h;
        gs.miss_pulse = m;
        gs.frame_tick = f;
        gs.start_btn = s;
        step();
        gs.hit_pulse = 1'b0;
        gs.miss_pulse = 1'b0;
        gs.frame_tick = 1'b0;
        gs.start_btn = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int p, input int l, input int pl, input int go, input int w);
        chk({tag, ".points"}, 32'(gs.points), p);
        chk({tag, ".lives"}, 32'(gs.lives), l);
        chk({tag, ".playing"}, 32'(gs.playing), pl);
        chk({tag, ".game_over"}, 32'(gs.game_over), go);
        chk({tag, ".game_won"}, 32'(gs.game_won), w);
    endtask

    initial begin
        gs.start_btn = 1'b0;
        gs.hit_pulse = 1'b0;
        gs.miss_pulse = 1'b0;
        gs.frame_tick = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk_all("reset", 0, 0, 0, 0, 0);
        pulse(1, 0, 0, 0);
        chk_all("idle_hit_ignored", 0, 0, 0, 0, 0);

        // start, score once, then hold the button: no restart may clear the point
        gs.start_btn = 1'b1;
        step();
        chk_all("start", 0, 3, 1, 0, 0);
        gs.hit_pulse = 1'b1;
        step();
        gs.hit_pulse = 1'b0;
        chk("held_hit1", 32'(gs.points), 1);
        for (int i = 0; i < 20; i++) step();
        chk_all("held_btn", 1, 3, 1, 0, 0);
        gs.start_btn = 1'b0;
        step();

        for (int i = 2; i <= 30; i++) begin
            pulse(1, 0, 0, 0);
            chk("hit_count", 32'(gs.points), i);
        end
        chk("pre_win_playing", 32'(gs.playing), 1);
        pulse(1, 0, 1, 0);
        chk_all("win", 31, 3, 0, 1, 1);
        pulse(1, 0, 0, 0);
        chk_all("over_hit_ignored", 31, 3, 0, 1, 1);
        pulse(0, 0, 0, 1);
        chk_all("over_start_ignored", 31, 3, 0, 1, 1);
        step();
        for (int i = 1; i <= 3; i++) begin
            pulse(0, 0, 1, 0);
            chk_all("hold_tick", 31, 3, 0, 1, 1);
        end
        pulse(0, 0, 1, 0);
        chk_all("hold_done_idle", 31, 3, 0, 0, 1);

        pulse(0, 0, 0, 1);
        chk_all("restart", 0, 3, 1, 0, 0);
        pulse(0, 1, 0, 0);
        chk_all("miss1", 0, 2, 1, 0, 0);
        pulse(0, 1, 0, 0);
        chk_all("miss2", 0, 1, 1, 0, 0);
        pulse(0, 1, 0, 0);
        chk_all("miss3_lose", 0, 0, 0, 1, 0);
        pulse(0, 1, 0, 0);
        chk_all("extra_miss", 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) pulse(0, 0, 1, 0);
        chk_all("lose_idle", 0, 0, 0, 0, 0);

        pulse(0, 0, 0, 1);
        chk_all("game3_start", 0, 3, 1, 0, 0);
        for (int i = 0; i < 30; i++) pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        chk_all("pre_tie", 30, 1, 1, 0, 0);
        pulse(1, 1, 0, 0);
        chk_all("tie_win", 31, 0, 0, 1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("rst_over", 0, 0, 0, 0, 0);

        pulse(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) pulse(1, 0, 0, 0);
        chk_all("mid_play", 7, 3, 1, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("rst_play", 0, 0, 0, 0, 0);
        step();
        pulse(0, 0, 0, 1);
        chk_all("post_rst_start", 0, 3, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
